// File: rtl/word_link_pkg.sv
// Shared definitions for the two-wire word-loading link: frame geometry and
// transmitter state encoding, used by the transmitter and the receiver bench model.
package word_link_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int FRAME_BITS = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } tx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/word_transmitter_phase_timer.sv
// Loadable down-counter with a terminal-count flag; times both the serial
// half-periods and the inter-frame gap of the word transmitter.
module phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/word_transmitter.sv
// Serializing bootloader transmitter: sends {addr, data} MSB-first with a strobe clock.
// Define WORD_TX_PARITY_EN to append an even-parity bit after bit 0.
module word_transmitter
  import word_link_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              serial_clk,
  output logic              serial_data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max_int(HALF_PERIOD, GAP_CYCLES) + 1);
`ifdef WORD_TX_PARITY_EN
  localparam int SHIFT_W = FRAME_BITS + 1;
`else
  localparam int SHIFT_W = FRAME_BITS;
`endif
  localparam int BIT_W = $clog2(SHIFT_W);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SHIFT_W - 1);

  tx_state_t          state;
  tx_state_t          next_state;
  logic [SHIFT_W-1:0] shreg;
  logic [SHIFT_W-1:0] frame_word;
  logic [BIT_W-1:0]   bit_cnt;
  logic               timer_load;
  logic [CNT_W-1:0]   timer_value;
  logic               phase_done;

`ifdef WORD_TX_PARITY_EN
  assign frame_word = {in_addr, in_data, ^{in_addr, in_data}};
`else
  assign frame_word = {in_addr, in_data};
`endif

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .tc         (phase_done)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every phase change reloads the timer with the length of the phase being entered.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = HALF_LOAD;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state = SETUP;
          timer_load = 1'b1;
        end
      end
      SETUP: begin
        if (phase_done) begin
          next_state = STROBE;
          timer_load = 1'b1;
        end
      end
      STROBE: begin
        if (phase_done) begin
          timer_load = 1'b1;
          if (bit_cnt == '0) begin
            next_state  = GAP;
            timer_value = GAP_LOAD;
          end else begin
            next_state = SETUP;
          end
        end
      end
      GAP: begin
        if (phase_done) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == GAP) && phase_done;
      if ((state == IDLE) && in_valid) begin
        shreg   <= frame_word;
        bit_cnt <= LAST_BIT;
      end else if ((state == STROBE) && phase_done && (bit_cnt != '0)) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  // The shift register is not cleared between frames, so the data line is gated by state.
  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign serial_clk  = (state == STROBE);
  assign serial_data = ((state == SETUP) || (state == STROBE)) && shreg[SHIFT_W-1];

endmodule

// File: tb/tb_word_transmitter.sv
// Scoreboard bench for word_transmitter: decodes the serial link and checks frames,
// done latency and gap length; a second HALF_PERIOD=1/GAP_CYCLES=1 instance is checked cycle by cycle.
module tb_word_transmitter;
  import word_link_pkg::*;

  localparam int HP   = 4;
  localparam int GAPC = 16;
`ifdef WORD_TX_PARITY_EN
  localparam int NBITS = FRAME_BITS + 1;
`else
  localparam int NBITS = FRAME_BITS;
`endif
  localparam int FRAME_TIME = NBITS * 2 * HP + GAPC;
  localparam int FAST_TIME  = NBITS * 2 + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [11:0] in_addr;
  logic [31:0] in_data;
  logic        in_ready, serial_clk, serial_data, busy, done;

  logic        fast_valid;
  logic [11:0] fast_addr;
  logic [31:0] fast_data;
  logic        fast_ready, fast_clk, fast_sdata, fast_busy, fast_done;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [44:0] exp_q[$];
  int          hs_q[$];
  int          b2b_hs = 0;
  int          ready_viol = 0;
  int          cap_cnt = 0;
  logic [44:0] cap = '0;
  logic        prev_clk = 1'b0;
  int          gap_cnt = 0;
  bit          gap_on = 1'b0;

  word_transmitter #(.HALF_PERIOD(HP), .GAP_CYCLES(GAPC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .serial_clk(serial_clk),
    .serial_data(serial_data), .busy(busy), .done(done)
  );

  word_transmitter #(.HALF_PERIOD(1), .GAP_CYCLES(1)) dut_fast (
    .clock(clock), .reset(reset), .in_valid(fast_valid), .in_ready(fast_ready),
    .in_addr(fast_addr), .in_data(fast_data), .serial_clk(fast_clk),
    .serial_data(fast_sdata), .busy(fast_busy), .done(fast_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [44:0] expFrame(input logic [11:0] a, input logic [31:0] d);
`ifdef WORD_TX_PARITY_EN
    return {a, d, ^{a, d}};
`else
    return {1'b0, a, d};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Receiver model: samples the link away from the clock edge and scores frames and timing.
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      hs_q.delete();
      cap_cnt  = 0;
      cap      = '0;
      gap_on   = 1'b0;
      prev_clk = 1'b0;
    end else begin
      if (done) begin
        if (hs_q.size() == 0) checkOutput("done_unexpected", 1, 0);
        else checkOutput("done_latency", cyc - hs_q.pop_front(), FRAME_TIME);
        if (gap_on) checkOutput("gap_length", gap_cnt, GAPC);
        gap_on = 1'b0;
        checkOutput("ready_vs_busy", ready_viol, 0);
        ready_viol = 0;
      end
      if (busy == in_ready) ready_viol++;
      if (gap_on && busy && !serial_clk) gap_cnt++;
      if (serial_clk && !prev_clk) begin
        cap = {cap[43:0], serial_data};
        cap_cnt++;
        if (cap_cnt == NBITS) begin
          if (exp_q.size() == 0) checkOutput("frame_unexpected", 1, 0);
          else checkOutput("frame", cap, exp_q.pop_front());
          cap_cnt = 0;
          cap     = '0;
          gap_on  = 1'b1;
          gap_cnt = 0;
        end
      end
      prev_clk = serial_clk;
      if (in_valid && in_ready) begin
        if (done) b2b_hs++;
        exp_q.push_back(expFrame(in_addr, in_data));
        hs_q.push_back(cyc + 1);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the handshake edge.
  task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d);
    int budget = 0;
    while (!in_ready && budget < 1000) begin
      @(posedge clock); #1;
      budget++;
    end
    if (budget >= 1000) checkOutput("ready_timeout", 0, 1);
    in_addr  = a;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int budget = 0;
    do begin
      @(posedge clock); #1;
      budget++;
    end while (!done && budget < 2000);
    if (!done) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic runFast();
    int          toggle_err = 0;
    int          done_at = -1;
    logic [44:0] fcap = '0;
    fast_addr  = 12'hABC;
    fast_data  = 32'h12345678;
    fast_valid = 1'b1;
    @(posedge clock); #1;
    fast_valid = 1'b0;
    for (int n = 1; n <= FAST_TIME + 2; n++) begin
      @(posedge clock); #1;
      if (fast_clk !== ((n < 2 * NBITS) ? logic'(n % 2) : 1'b0)) toggle_err++;
      if (fast_clk) fcap = {fcap[43:0], fast_sdata};
      if (fast_done && done_at < 0) done_at = n;
    end
    checkOutput("fast_toggle", toggle_err, 0);
    checkOutput("fast_frame", fcap, expFrame(12'hABC, 32'h12345678));
    checkOutput("fast_done_cycle", done_at, FAST_TIME);
  endtask

  initial begin
    int b2b_before;
    int budget;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_addr    = '0;
    in_data    = '0;
    fast_valid = 1'b0;
    fast_addr  = '0;
    fast_data  = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    checkOutput("reset_ready", in_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sclk", serial_clk, 0);
    checkOutput("reset_sdata", serial_data, 0);
    checkOutput("reset_done", done, 0);

    applyStimulus(12'h123, 32'hDEADBEEF);
    waitDone();

    // Back-to-back with in_valid held: the second word must be taken on the done cycle.
    @(posedge clock); #1;
    b2b_before = b2b_hs;
    in_addr  = 12'h000;
    in_data  = 32'h00000001;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_addr  = 12'hFFF;
    in_data  = 32'h80000000;
    budget = 0;
    while (!in_ready && budget < 1000) begin
      @(posedge clock); #1;
      budget++;
    end
    if (budget >= 1000) checkOutput("b2b_ready_timeout", 0, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    waitDone();
    checkOutput("b2b_on_done", b2b_hs - b2b_before, 1);

    // Input churn while busy must not disturb the frame in flight.
    @(posedge clock); #1;
    applyStimulus(12'h3C5, 32'h0F1E2D3C);
    for (int i = 0; i < 300; i++) begin
      in_addr = 12'($urandom);
      in_data = $urandom;
      @(posedge clock); #1;
    end
    waitDone();

    // Reset at cycle 100 of a frame abandons it.
    @(posedge clock); #1;
    applyStimulus(12'h7A1, 32'hFFFFFFFF);
    repeat (98) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    checkOutput("midreset_sclk", serial_clk, 0);
    checkOutput("midreset_sdata", serial_data, 0);
    checkOutput("midreset_ready", in_ready, 1);
    checkOutput("midreset_done", done, 0);
    repeat (5) begin
      @(posedge clock); #1;
    end
    checkOutput("midreset_no_done", done, 0);
    applyStimulus(12'h055, 32'h5A5A5A5A);
    waitDone();

    @(posedge clock); #1;
    applyStimulus(12'h001, 32'h00000003);
    waitDone();

    @(posedge clock); #1;
    runFast();

    repeat (3) begin
      @(posedge clock); #1;
    end
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
